control_turnos: RTL
===================

CONTROL_TURNOS -- requirements
Module: control_turnos

Interface
REQ-001 Parameter: JUGADOR_INICIAL, default 1, player owning the first turn of every game (1 or 2).
REQ-002 Parameter: TIEMPO_TURNO, default 100, clock cycles a player may hold a turn before forfeiting it; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 inicio  input  1  one-cycle start/restart request.
REQ-006 jugada1_valida  input  1  player 1 move request, qualified by jugada1_celda.
REQ-007 jugada1_celda  input  4  player 1 cell index, legal 0-8.
REQ-008 jugada2_valida  input  1  player 2 move request.
REQ-009 jugada2_celda  input  4  player 2 cell index, legal 0-8.
REQ-010 registro_salida  output  6  board register word {jugador[1:0], celda[3:0]}; jugador 01=J1, 10=J2.
REQ-011 registro_escribe  output  1  one-cycle write strobe qualifying registro_salida.
REQ-012 turno  output  2  01 J1 to move, 10 J2 to move, 00 no turn open.
REQ-013 jugada_rechazada  output  1  one-cycle pulse for an illegal move by the turn owner.
REQ-014 ganador  output  2  00 none, 01 J1, 10 J2, 11 tie.
REQ-015 juego_activo  output  1  high from game start until game end.
REQ-016 contador_jugadas  output  4  accepted moves in current game, 0-9.

Function
REQ-017 FSM states: ESPERA, TURNO_J1, TURNO_J2, ESCRIBE, FIN; all outputs registered.
REQ-018 ESPERA or FIN + inicio: clear both 9-bit occupancy masks, contador_jugadas, ganador, turn timer; next state TURNO_J1 or TURNO_J2 per JUGADOR_INICIAL; juego_activo=1.
REQ-019 inicio while juego_activo=1 is ignored.
REQ-020 turno reflects state: 01 in TURNO_J1, 10 in TURNO_J2, 00 otherwise.
REQ-021 In TURNO_Jx only the owner's valid is sampled; the other player's valid is ignored with no pulse.
REQ-022 Owner valid with celda>8 or cell occupied in either mask: jugada_rechazada=1 next cycle, state unchanged, timer not restarted, no write.
REQ-023 Owner valid with legal free cell at edge N: after edge N, registro_escribe=1 for exactly one cycle, registro_salida={owner,celda}, owner mask bit set, contador_jugadas+1, state ESCRIBE.
REQ-024 registro_salida holds its last value between strobes.
REQ-025 ESCRIBE (one cycle): owner mask matches any of the 8 lines (3 rows, 3 columns, 2 diagonals) -> FIN, ganador=owner; else contador_jugadas=9 -> FIN, ganador=11; else the other player's TURNO state, timer cleared.
REQ-026 Win is checked before tie; a win on move 9 reports the player, not 11.
REQ-027 Timer counts cycles in TURNO_Jx; reaching TIEMPO_TURNO-1 with no accepted move passes the turn to the other player: no write, no pulse, timer cleared, count unchanged.
REQ-028 A legal valid in the expiry cycle is accepted; the move wins over the timeout.
REQ-029 FIN: juego_activo=0, turno=00; ganador, contador_jugadas, registro_salida hold until inicio or reset.
REQ-030 Accept-to-next-turn latency: 2 cycles (strobe cycle = ESCRIBE cycle, new turno visible after it).

Reset
REQ-031 reset sampled high: state ESPERA, registro_salida=000000, registro_escribe=0, turno=00, jugada_rechazada=0, ganador=00, juego_activo=0, contador_jugadas=0, masks and timer cleared.
REQ-032 reset has priority over inicio and all move inputs in the same cycle; mid-game reset aborts the game with no write.

Verification
REQ-033 reset, inicio, J1 celda 4 -> strobe word 010100, turno 10 two cycles after acceptance, count 1.
REQ-034 J1 cells 0,1,2 interleaved with J2 cells 3,4 -> five strobes, ganador=01, juego_activo=0, count 5.
REQ-035 J2 picks occupied cell 4, then celda 9 -> two rejection pulses, no strobe, turno stays 10; J1 valid during J2's turn ignored.
REQ-036 Nine legal moves with no line (e.g. J1 0,2,3,7,5 / J2 1,4,6,8) -> ganador=11, count 9.
REQ-037 TIEMPO_TURNO=4, J1 idle -> turno 01->10 after 4 cycles, no strobe; legal move in expiry cycle -> accepted.
REQ-038 reset asserted same cycle as legal J1 move mid-game -> no strobe, all outputs at reset values.

Source files
------------

// File: rtl/control_turnos.sv
// control_turnos: turn controller for a two-player 3x3 board game.
// Ports:
//   clk, reset                sync active-high reset
//   inicio                    start/restart request (ignored mid-game)
//   jugadaN_valida/_celda     move request and cell 0-8 of player N
//   registro_salida/_escribe  {jugador,celda} board word + write strobe
//   turno                     01 J1, 10 J2, 00 no turn open
//   jugada_rechazada          pulse for an illegal move by the turn owner
//   ganador                   00 none, 01 J1, 10 J2, 11 tie
//   juego_activo              high while a game is in progress
//   contador_jugadas          accepted moves in the current game
module control_turnos #(
   parameter int JUGADOR_INICIAL = 1,
   parameter int TIEMPO_TURNO    = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inicio,
   input  logic       jugada1_valida,
   input  logic [3:0] jugada1_celda,
   input  logic       jugada2_valida,
   input  logic [3:0] jugada2_celda,
   output logic [5:0] registro_salida,
   output logic       registro_escribe,
   output logic [1:0] turno,
   output logic       jugada_rechazada,
   output logic [1:0] ganador,
   output logic       juego_activo,
   output logic [3:0] contador_jugadas
);

   localparam int TW = (TIEMPO_TURNO > 2) ? $clog2(TIEMPO_TURNO) : 1;
   localparam logic [TW-1:0] T_FIN =
      TW'((TIEMPO_TURNO > 0) ? TIEMPO_TURNO - 1 : 0);
   localparam logic T_ON = (TIEMPO_TURNO != 0);
   localparam logic [1:0] J_INI =
      (JUGADOR_INICIAL == 2) ? 2'b10 : 2'b01;

   typedef enum logic [2:0] {
      ESPERA,
      TURNO_J1,
      TURNO_J2,
      ESCRIBE,
      FIN
   } estado_t;

   estado_t       estado_q;
   logic [8:0]    mask1_q, mask2_q;
   logic [TW-1:0] timer_q;
   logic [1:0]    dueno_q;
   logic [5:0]    salida_q;
   logic          escribe_q;
   logic [1:0]    turno_q;
   logic          rech_q;
   logic [1:0]    ganador_q;
   logic          activo_q;
   logic [3:0]    cuenta_q;

   logic [1:0]    jug;
   logic          valida;
   logic [3:0]    celda;
   logic [8:0]    celda_oh;
   logic          legal;
   logic          vence;
   logic          gana;
   logic [8:0]    mask1_d, mask2_d;
   logic [3:0]    cuenta_d;

   function automatic logic tres_en_linea(input logic [8:0] m);
      return (&m[2:0]) | (&m[5:3]) | (&m[8:6])
           | (m[0] & m[3] & m[6])
           | (m[1] & m[4] & m[7])
           | (m[2] & m[5] & m[8])
           | (m[0] & m[4] & m[8])
           | (m[2] & m[4] & m[6]);
   endfunction

   // Only the turn owner's request is looked at.
   always_comb begin
      jug    = 2'b00;
      valida = 1'b0;
      celda  = 4'd0;
      unique case (estado_q)
         TURNO_J1: begin
            jug    = 2'b01;
            valida = jugada1_valida;
            celda  = jugada1_celda;
         end
         TURNO_J2: begin
            jug    = 2'b10;
            valida = jugada2_valida;
            celda  = jugada2_celda;
         end
         default: ;
      endcase
   end

   // A shift past bit 8 yields zero, so out-of-range cells have no
   // one-hot bit and never alias onto a real square.
   assign celda_oh = 9'd1 << celda;
   assign legal    = valida && (celda <= 4'd8) &&
                     ((celda_oh & (mask1_q | mask2_q)) == 9'd0);
   assign vence    = T_ON && (timer_q == T_FIN);
   assign mask1_d  = mask1_q | (jug[0] ? celda_oh : 9'd0);
   assign mask2_d  = mask2_q | (jug[1] ? celda_oh : 9'd0);
   assign cuenta_d = cuenta_q + 4'd1;
   assign gana     = tres_en_linea(dueno_q[1] ? mask2_q : mask1_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q  <= ESPERA;
         mask1_q   <= '0;
         mask2_q   <= '0;
         timer_q   <= '0;
         dueno_q   <= 2'b00;
         salida_q  <= 6'd0;
         escribe_q <= 1'b0;
         turno_q   <= 2'b00;
         rech_q    <= 1'b0;
         ganador_q <= 2'b00;
         activo_q  <= 1'b0;
         cuenta_q  <= 4'd0;
      end else begin
         escribe_q <= 1'b0;
         rech_q    <= 1'b0;
         unique case (estado_q)
            ESPERA, FIN: begin
               if (inicio) begin
                  mask1_q   <= '0;
                  mask2_q   <= '0;
                  cuenta_q  <= 4'd0;
                  ganador_q <= 2'b00;
                  timer_q   <= '0;
                  activo_q  <= 1'b1;
                  turno_q   <= J_INI;
                  estado_q  <= J_INI[1] ? TURNO_J2 : TURNO_J1;
               end
            end
            TURNO_J1, TURNO_J2: begin
               if (legal) begin
                  // A legal move in the expiry cycle still wins.
                  estado_q  <= ESCRIBE;
                  escribe_q <= 1'b1;
                  salida_q  <= {jug, celda};
                  mask1_q   <= mask1_d;
                  mask2_q   <= mask2_d;
                  cuenta_q  <= cuenta_d;
                  dueno_q   <= jug;
                  turno_q   <= 2'b00;
               end else begin
                  rech_q <= valida;
                  if (vence) begin
                     estado_q <= jug[0] ? TURNO_J2 : TURNO_J1;
                     turno_q  <= {jug[0], jug[1]};
                     timer_q  <= '0;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end
            ESCRIBE: begin
               // Win takes precedence over a full board.
               if (gana) begin
                  estado_q  <= FIN;
                  ganador_q <= dueno_q;
                  activo_q  <= 1'b0;
               end else if (cuenta_q == 4'd9) begin
                  estado_q  <= FIN;
                  ganador_q <= 2'b11;
                  activo_q  <= 1'b0;
               end else begin
                  estado_q <= dueno_q[0] ? TURNO_J2 : TURNO_J1;
                  turno_q  <= {dueno_q[0], dueno_q[1]};
                  timer_q  <= '0;
               end
            end
            default: estado_q <= ESPERA;
         endcase
      end
   end

   assign registro_salida  = salida_q;
   assign registro_escribe = escribe_q;
   assign turno            = turno_q;
   assign jugada_rechazada = rech_q;
   assign ganador          = ganador_q;
   assign juego_activo     = activo_q;
   assign contador_jugadas = cuenta_q;

endmodule
